// File: rtl/conv_pkg.sv
// Shared types, FSM encoding and output clamp for the 3x3 convolution stage.
// CONV3X3_RELU_EN selects ReLU + unsigned clamp; otherwise signed saturation.
package conv_pkg;

    localparam int unsigned KSIZE = 3;

    typedef logic        [7:0]  pixel_t;
    typedef logic signed [7:0]  weight_t;
    typedef logic signed [20:0] acc_t;
    typedef weight_t            kernel_t [KSIZE*KSIZE];

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    function automatic logic [7:0] clamp8(input acc_t v);
`ifdef CONV3X3_RELU_EN
        if (v < 21'sd0) begin
            return 8'd0;
        end else if (v > 21'sd255) begin
            return 8'd255;
        end
        return v[7:0];
`else
        if (v > 21'sd127) begin
            return 8'h7f;
        end else if (v < -21'sd128) begin
            return 8'h80;
        end
        return v[7:0];
`endif
    endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream, weight write port and result stream of the convolution stage.
interface conv3x3_stream_if
    import conv_pkg::*;
();
    logic       in_valid;
    pixel_t     in_pixel;
    logic       w_load;
    logic [3:0] w_idx;
    weight_t    w_data;
    logic       w_err;
    logic       conv_valid;
    logic [7:0] conv_result;
    logic       busy;
    logic       frame_done;

    modport master (
        output in_valid, in_pixel, w_load, w_idx, w_data,
        input  w_err, conv_valid, conv_result, busy, frame_done
    );

    modport slave (
        input  in_valid, in_pixel, w_load, w_idx, w_data,
        output w_err, conv_valid, conv_result, busy, frame_done
    );
endinterface

// File: rtl/conv_line_buffer.sv
// Two-row line buffer: returns the vertical 3-pixel column ending at the current pixel.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter  int unsigned IMG_W = 6,
    localparam int unsigned CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [CW-1:0] i_col,
    input  pixel_t        i_pixel,
    output pixel_t        o_top,
    output pixel_t        o_mid,
    output pixel_t        o_bot
);

    pixel_t r_row1 [IMG_W];
    pixel_t r_row2 [IMG_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(IMG_W); i++) begin
                r_row1[i] <= '0;
                r_row2[i] <= '0;
            end
        end else if (i_valid) begin
            r_row2[i_col] <= r_row1[i_col];
            r_row1[i_col] <= i_pixel;
        end
    end

    assign o_top = r_row2[i_col];
    assign o_mid = r_row1[i_col];
    assign o_bot = i_pixel;

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution, 2-stage pipeline (products, then sum/shift/clamp).
// Build option CONV3X3_RELU_EN switches the output clamp to ReLU + unsigned.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 6,
    parameter int unsigned IMG_H = 6,
    parameter int unsigned SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    conv3x3_stream_if.slave        bus
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned NK = KSIZE * KSIZE;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pend;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    kernel_t             r_kernel;
    pixel_t              r_win     [KSIZE][KSIZE];
    pixel_t              w_win_nxt [KSIZE][KSIZE];
    logic signed [16:0]  w_prod    [NK];
    logic signed [16:0]  r_prod    [NK];
    logic                r_v1, r_last1;
    logic                r_v2, r_last2;
    logic [7:0]          r_res;
    logic                r_werr;
    acc_t                w_sum;
    acc_t                w_shift;
    pixel_t              w_top, w_mid, w_bot;
    logic                w_last_col, w_last_pix, w_win_ok, w_wr_ok;

    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_pix = w_last_col && (r_row == RW'(IMG_H - 1));
    assign w_win_ok   = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_wr_ok    = bus.w_load && (r_state == IDLE) && (bus.w_idx <= 4'd8);

    conv_line_buffer #(
        .IMG_W (IMG_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.in_valid),
        .i_col   (r_col),
        .i_pixel (bus.in_pixel),
        .o_top   (w_top),
        .o_mid   (w_mid),
        .o_bot   (w_bot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.in_valid) begin
            r_col <= w_last_col ? '0 : r_col + CW'(1);
            if (w_last_col) begin
                r_row <= w_last_pix ? '0 : r_row + RW'(1);
            end
        end
    end

    // Products are taken from the window including the pixel being accepted now.
    always_comb begin
        for (int kr = 0; kr < int'(KSIZE); kr++) begin
            w_win_nxt[kr][0] = r_win[kr][1];
            w_win_nxt[kr][1] = r_win[kr][2];
        end
        w_win_nxt[0][2] = w_top;
        w_win_nxt[1][2] = w_mid;
        w_win_nxt[2][2] = w_bot;
        for (int i = 0; i < int'(NK); i++) begin
            w_prod[i] = 17'($signed({1'b0, w_win_nxt[i / KSIZE][i % KSIZE]}))
                      * 17'(r_kernel[i]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(NK); i++) begin
            w_sum = w_sum + acc_t'(r_prod[i]);
        end
        w_shift = w_sum >>> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int kr = 0; kr < int'(KSIZE); kr++) begin
                for (int kc = 0; kc < int'(KSIZE); kc++) begin
                    r_win[kr][kc] <= '0;
                end
            end
            for (int i = 0; i < int'(NK); i++) begin
                r_prod[i]   <= '0;
                r_kernel[i] <= '0;
            end
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_res   <= '0;
            r_werr  <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                r_win <= w_win_nxt;
            end
            r_prod  <= w_prod;
            r_v1    <= bus.in_valid && w_win_ok;
            r_last1 <= bus.in_valid && w_win_ok && w_last_pix;
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            r_res   <= r_v1 ? clamp8(w_shift) : r_res;
            r_werr  <= bus.w_load && !w_wr_ok;
            if (w_wr_ok) begin
                r_kernel[bus.w_idx] <= bus.w_data;
            end
        end
    end

    // A pixel seen during FLUSH already started the next frame; remember it.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = ACTIVE;
            ACTIVE:  if (bus.in_valid && w_last_pix) w_state_nxt = FLUSH;
            FLUSH:   if (r_last2) w_state_nxt = (r_pend || bus.in_valid) ? ACTIVE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != FLUSH) begin
                r_pend <= 1'b0;
            end else if (r_state == FLUSH && bus.in_valid) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign bus.w_err       = r_werr;
    assign bus.conv_valid  = r_v2;
    assign bus.conv_result = r_res;
    assign bus.frame_done  = r_last2;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: directed frames, expected results queued at issue time.
module tb_conv3x3_stream;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    conv3x3_stream_if bus ();

    conv3x3_stream #(
        .IMG_W (6),
        .IMG_H (6),
        .SHIFT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        bit last;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    int id_exp [16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};
`ifdef CONV3X3_RELU_EN
    localparam int SAT_EXP = 255;
    localparam int NEG_EXP = 0;
`else
    localparam int SAT_EXP = 127;
    localparam int NEG_EXP = 250;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pops the oldest expectation.
    always @(negedge clk) begin
        if (bus.conv_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("conv_result", int'(bus.conv_result), e.val);
                check("frame_done_flag", int'(bus.frame_done), int'(e.last));
                check("result_cycle", cyc, e.cyc);
            end
        end else if (bus.frame_done) begin
            check("frame_done_without_valid", 1, 0);
        end
    end

    task automatic load_w(input int idx, input int data, input int exp_err, input string name);
        @(negedge clk);
        bus.w_load = 1'b1;
        bus.w_idx  = 4'(idx);
        bus.w_data = 8'(data);
        @(negedge clk);
        check(name, int'(bus.w_err), exp_err);
        bus.w_load = 1'b0;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 9; i++) load_w(i, (i == 4) ? 16 : 0, 0, "w_err_ok");
    endtask

    task automatic set_all(input int data);
        for (int i = 0; i < 9; i++) load_w(i, data, 0, "w_err_ok");
    endtask

    // kind 0: identity ramp, 1: all 255, 2: all 10
    task automatic send_frame(input int kind, input int gap, input int werr_at, input int npix,
                              input bit idle_after);
        int n = 0;
        int k = 0;
        bit werr_chk = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (n < npix) begin
                    @(negedge clk);
                    if (werr_chk) begin
                        check("w_err_active", int'(bus.w_err), 1);
                        bus.w_load = 1'b0;
                        werr_chk = 1'b0;
                    end
                    if (n == 1) check("busy_in_frame", int'(bus.busy), 1);
                    bus.in_valid = 1'b1;
                    bus.in_pixel = (kind == 0) ? 8'(6 * r + c) : (kind == 1) ? 8'd255 : 8'd10;
                    if (n == werr_at) begin
                        bus.w_load = 1'b1;
                        bus.w_idx  = 4'd4;
                        bus.w_data = 8'd0;
                        werr_chk   = 1'b1;
                    end
                    if (r >= 2 && c >= 2) begin
                        exp_t e;
                        e.val  = (kind == 0) ? id_exp[k] : (kind == 1) ? SAT_EXP : NEG_EXP;
                        e.last = (r == 5 && c == 5);
                        e.cyc  = cyc + 2;
                        exp_q.push_back(e);
                        k++;
                    end
                    n++;
                    for (int g = 0; g < gap; g++) begin
                        @(negedge clk);
                        if (werr_chk) begin
                            check("w_err_active", int'(bus.w_err), 1);
                            bus.w_load = 1'b0;
                            werr_chk = 1'b0;
                        end
                        bus.in_valid = 1'b0;
                    end
                end
            end
        end
        if (idle_after) begin
            @(negedge clk);
            if (werr_chk) begin
                check("w_err_active", int'(bus.w_err), 1);
                bus.w_load = 1'b0;
            end
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("busy_idle_after_frame", int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.w_load   = 1'b0;
        bus.w_idx    = '0;
        bus.w_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_conv_valid", int'(bus.conv_valid), 0);
        check("rst_conv_result", int'(bus.conv_result), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_w_err", int'(bus.w_err), 0);
        rst = 1'b0;

        set_identity();
        send_frame(0, 0, -1, 36, 1'b1);
        drain();

        // Rejected write mid-frame must not disturb the kernel.
        send_frame(0, 0, 8, 36, 1'b1);
        drain();
        load_w(12, 0, 1, "w_err_idx12");
        send_frame(0, 0, -1, 36, 1'b1);
        drain();

        send_frame(0, 1, -1, 36, 1'b1);
        drain();

        // Back-to-back frames: second frame starts during FLUSH.
        send_frame(0, 0, -1, 36, 1'b0);
        send_frame(0, 0, -1, 36, 1'b1);
        drain();

        send_frame(0, 0, -1, 20, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_conv_valid", int'(bus.conv_valid), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_frame_done", int'(bus.frame_done), 0);
        check("midrst_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("midrst_quiet", int'(bus.conv_valid), 0);
        set_identity();
        send_frame(0, 0, -1, 36, 1'b1);
        drain();

        set_all(16);
        send_frame(1, 0, -1, 36, 1'b1);
        drain();

        set_all(-1);
        send_frame(2, 0, -1, 36, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
